// File: rtl/trace_reorder_buffer_pkg.sv
// Shared trace event types, default latency-slot assignments and small helpers
// for the trace reorder buffer.
package trace_reorder_buffer_pkg;

    localparam int TRACE_EVENT_WIDTH = 600;

    typedef enum logic [1:0] {
        TE_INVALID    = 2'd0,
        TE_SWRITEBACK = 2'd1,
        TE_VWRITEBACK = 2'd2,
        TE_STORE      = 2'd3
    } trace_event_type_t;

    // An all-zero event decodes as TE_INVALID, so a zero payload means "no event".
    typedef struct packed {
        trace_event_type_t               etype;
        logic [TRACE_EVENT_WIDTH-3:0]    data;
    } trace_event_t;

    localparam int TRACE_SLOT_MULTI  = 0;
    localparam int TRACE_SLOT_MEM    = 3;
    localparam int TRACE_SLOT_SCYCLE = 4;
    localparam int TRACE_SLOT_STORE  = 5;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/trace_reorder_buffer_out_fifo.sv
// Synchronous output FIFO for the trace reorder buffer: flop storage, no bypass,
// push accepted when full if the head is popped in the same cycle.
module trace_reorder_out_fifo
    import trace_reorder_buffer_pkg::*;
#(
    parameter int WIDTH = TRACE_EVENT_WIDTH,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             can_push,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             pop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = !empty && out_ready;
    assign can_push  = !full || pop;
    assign out_valid = !empty;
    // Storage is not reset; masking keeps the head at zero while empty.
    assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && can_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)              rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && can_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/trace_reorder_buffer.sv
// Latency-slot reorder queue for trace events feeding an output FIFO.
// Define TRACE_REORDER_STATS_EN to build the drop/collision counters.
module trace_reorder_buffer
    import trace_reorder_buffer_pkg::*;
#(
    parameter int DEPTH       = 7,
    parameter int NUM_PORTS   = 3,
    parameter int EVENT_WIDTH = TRACE_EVENT_WIDTH,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic [NUM_PORTS-1:0]                           ins_valid,
    input  logic [NUM_PORTS-1:0][$clog2(DEPTH)-1:0]        ins_slot,
    input  logic [NUM_PORTS-1:0][EVENT_WIDTH-1:0]          ins_event,
    input  logic                                           kill_en,
    input  logic [$clog2(DEPTH)-1:0]                       kill_slot,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [EVENT_WIDTH-1:0]                         out_event,
    output logic                                           overflow,
    output logic                                           collision,
    input  logic                                           clear_errors,
    output logic [15:0]                                    drop_count,
    output logic [15:0]                                    collision_count
);

    // Registers hold the post-shift view, so slot k is drained k cycles later.
    logic [DEPTH-1:0]       slot_vld;
    logic [EVENT_WIDTH-1:0] slot_evt [DEPTH];
    logic [DEPTH-1:0]       eff_vld;
    logic [EVENT_WIDTH-1:0] eff_evt  [DEPTH];
    logic [NUM_PORTS-1:0]   coll_port;
    logic                   can_push;
    logic                   drop;
    logic                   any_coll;

    // Descending port order lets the lowest-numbered port win a shared slot.
    always_comb begin
        eff_vld   = slot_vld;
        eff_evt   = slot_evt;
        coll_port = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (ins_valid[p]) begin
                if (int'(ins_slot[p]) >= DEPTH) begin
                    coll_port[p] = 1'b1;
                end else begin
                    if (slot_vld[ins_slot[p]]) coll_port[p] = 1'b1;
                    for (int q = 0; q < p; q++) begin
                        if (ins_valid[q] && ins_slot[q] == ins_slot[p]) coll_port[p] = 1'b1;
                    end
                    eff_vld[ins_slot[p]] = 1'b1;
                    eff_evt[ins_slot[p]] = ins_event[p];
                end
            end
        end
        if (kill_en && int'(kill_slot) < DEPTH) eff_vld[kill_slot] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) slot_vld <= '0;
        else       slot_vld <= {1'b0, eff_vld[DEPTH-1:1]};
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH - 1; i++) slot_evt[i] <= eff_evt[i+1];
        slot_evt[DEPTH-1] <= '0;
    end

    trace_reorder_out_fifo #(
        .WIDTH (EVENT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (eff_vld[0]),
        .push_data (eff_evt[0]),
        .can_push  (can_push),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_event)
    );

    assign drop     = eff_vld[0] && !can_push;
    assign any_coll = |coll_port;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            collision <= 1'b0;
        end else if (clear_errors) begin
            overflow  <= drop;
            collision <= any_coll;
        end else begin
            overflow  <= overflow | drop;
            collision <= collision | any_coll;
        end
    end

`ifdef TRACE_REORDER_STATS_EN
    logic [15:0] coll_n;

    always_comb begin
        coll_n = '0;
        for (int p = 0; p < NUM_PORTS; p++) coll_n = coll_n + 16'(coll_port[p]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count      <= '0;
            collision_count <= '0;
        end else if (clear_errors) begin
            drop_count      <= 16'(drop);
            collision_count <= coll_n;
        end else begin
            drop_count      <= sat_add16(drop_count, 16'(drop));
            collision_count <= sat_add16(collision_count, coll_n);
        end
    end
`else
    assign drop_count      = '0;
    assign collision_count = '0;
`endif

endmodule

// File: tb/tb_trace_reorder_buffer.sv
// Directed bench for trace_reorder_buffer: latency, ordering, collisions, kill,
// FIFO overflow and mid-flight reset, with hand-computed expectations.
module tb_trace_reorder_buffer;
    localparam int DEPTH = 7;
    localparam int NP    = 3;
    localparam int EW    = 600;
    localparam int FD    = 8;
    localparam int SW    = $clog2(DEPTH);
`ifdef TRACE_REORDER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NP-1:0]            ins_valid;
    logic [NP-1:0][SW-1:0]    ins_slot;
    logic [NP-1:0][EW-1:0]    ins_event;
    logic                     kill_en;
    logic [SW-1:0]            kill_slot;
    logic                     out_valid;
    logic                     out_ready;
    logic [EW-1:0]            out_event;
    logic                     overflow;
    logic                     collision;
    logic                     clear_errors;
    logic [15:0]              drop_count;
    logic [15:0]              collision_count;

    int n_vec = 0;
    int n_err = 0;

    trace_reorder_buffer #(
        .DEPTH(DEPTH), .NUM_PORTS(NP), .EVENT_WIDTH(EW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .reset(reset), .ins_valid(ins_valid), .ins_slot(ins_slot),
        .ins_event(ins_event), .kill_en(kill_en), .kill_slot(kill_slot),
        .out_valid(out_valid), .out_ready(out_ready), .out_event(out_event),
        .overflow(overflow), .collision(collision), .clear_errors(clear_errors),
        .drop_count(drop_count), .collision_count(collision_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ins_valid    = '0;
        kill_en      = 1'b0;
        clear_errors = 1'b0;
    endtask

    task automatic ins(input int p, input int s, input logic [EW-1:0] ev);
        ins_valid[p] = 1'b1;
        ins_slot[p]  = SW'(s);
        ins_event[p] = ev;
    endtask

    task automatic chk_clean(input string tag);
        chk({tag, "_ovf"},  EW'(overflow), '0);
        chk({tag, "_col"},  EW'(collision), '0);
        chk({tag, "_dcnt"}, EW'(drop_count), '0);
        chk({tag, "_ccnt"}, EW'(collision_count), '0);
    endtask

    initial begin
        bit seen;
        reset     = 1'b1;
        ins_slot  = '0;
        ins_event = '0;
        kill_slot = '0;
        out_ready = 1'b1;
        idle();
        step(); step();
        reset = 1'b0;
        chk("rst_vld", EW'(out_valid), '0);
        chk("rst_evt", out_event, '0);
        chk_clean("rst");

        // single insert, slot 4: visible 5 cycles later
        ins(0, 4, EW'('hA5));
        step(); idle();
        step(); step(); step();
        chk("s4_early", EW'(out_valid), '0);
        step();
        chk("s4_vld", EW'(out_valid), EW'(1));
        chk("s4_evt", out_event, EW'('hA5));
        step();
        chk("s4_drained", EW'(out_valid), '0);
        chk_clean("s4");

        // out-of-order completion: A slot4@0, B slot2@3, C slot0@6 -> A,B,C at 5,6,7
        ins(1, 4, EW'('hAA));
        step(); idle();
        step(); step();
        ins(2, 2, EW'('hBB));
        step(); idle();
        step();
        chk("ooo_a", out_event, EW'('hAA));
        step();
        ins(0, 0, EW'('hCC));
        chk("ooo_b", out_event, EW'('hBB));
        step(); idle();
        chk("ooo_c", out_event, EW'('hCC));
        step();
        chk("ooo_end", EW'(out_valid), '0);
        chk("ooo_col", EW'(collision), '0);

        // two ports on slot 2: port 0 wins, one collision
        ins(0, 2, EW'('h11));
        ins(2, 2, EW'('h33));
        step(); idle();
        chk("dup_col", EW'(collision), EW'(1));
        chk("dup_ccnt", EW'(collision_count), STATS ? EW'(1) : '0);
        step(); step();
        chk("dup_vld", EW'(out_valid), EW'(1));
        chk("dup_evt", out_event, EW'('h11));
        step();
        chk("dup_single", EW'(out_valid), '0);
        clear_errors = 1'b1;
        step(); idle();
        chk("clr_col", EW'(collision), '0);
        chk("clr_ccnt", EW'(collision_count), '0);

        // insert and kill the same slot
        ins(1, 4, EW'('h77));
        kill_en   = 1'b1;
        kill_slot = SW'(4);
        step(); idle();
        seen = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        chk("kill_none", EW'(seen), '0);
        chk("kill_col", EW'(collision), '0);

        // overflow: 10 events into a stalled 8-entry FIFO
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ins(0, 0, EW'(256 + i));
            step();
        end
        idle();
        chk("ovf_flag", EW'(overflow), EW'(1));
        chk("ovf_dcnt", EW'(drop_count), STATS ? EW'(2) : '0);
        chk("ovf_col", EW'(collision), '0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf_vld%0d", i), EW'(out_valid), EW'(1));
            chk($sformatf("ovf_evt%0d", i), out_event, EW'(256 + i));
            step();
        end
        chk("ovf_empty", EW'(out_valid), '0);
        clear_errors = 1'b1;
        step(); idle();
        chk("ovf_clr", EW'(overflow), '0);

        // reset with 3 events in slots, 2 in the FIFO, collision set
        out_ready = 1'b0;
        ins(0, 0, EW'('hD1));
        ins(1, 4, EW'('hE1));
        ins(2, 7, EW'('hF0));
        step(); idle();
        ins(0, 0, EW'('hD2));
        ins(1, 4, EW'('hE2));
        ins(2, 5, EW'('hE3));
        step(); idle();
        chk("pre_rst_vld", EW'(out_valid), EW'(1));
        chk("pre_rst_col", EW'(collision), EW'(1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        chk("mid_rst_vld", EW'(out_valid), '0);
        chk("mid_rst_evt", out_event, '0);
        chk_clean("mid_rst");
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        chk("mid_rst_quiet", EW'(seen), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
